scan_decoder: RTL and testbench



---
 rtl/scan_decoder.sv | 127 ++++++++++++
 tb/tb_scan_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered N-to-2^N one-hot decoder with two modes:
//     mode = 0 : direct decode of sel
//     mode = 1 : decode of an internal scan index that can be loaded, stepped
//                (mod 2^N) and reports a one-cycle wrap pulse.
//   Every output is driven straight from a flop, so there is no combinational
//   path from any input to any output.
//
//   Optional build macro: SCAN_DECODER_DOWN_EN
//     When defined, adds input port dir; dir = 1 makes step decrement the
//     index (wrap pulses on the 0 -> 2^N-1 transition). dir = 0 behaves as the
//     default up-only build. When undefined there is no dir port.
//
//   N is intended to be in the range 1..6.
// -----------------------------------------------------------------------------
module scan_decoder #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       sel,
    input  logic               load,
    input  logic               step,
`ifdef SCAN_DECODER_DOWN_EN
    input  logic               dir,
`endif
    output logic [(1<<N)-1:0]  w,
    output logic [N-1:0]       idx,
    output logic               wrap
);

    localparam int W = 1 << N;

    // Index constants sized to the index width.
    localparam logic [N-1:0] IDX_ZERO = {N{1'b0}};
    localparam logic [N-1:0] IDX_ONE  = N'(1'b1);
    localparam logic [N-1:0] IDX_MAX  = {N{1'b1}};
    localparam logic [W-1:0] W_ZERO   = {W{1'b0}};
    localparam logic [W-1:0] W_ONE    = W'(1'b1);

    // One-hot encode of an index value: bit v set, all others clear.
    function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
        return W_ONE << v;
    endfunction

    // Registered state and next-state values.
    logic [W-1:0] w_q;
    logic [W-1:0] w_d;
    logic [N-1:0] idx_q;
    logic [N-1:0] idx_d;
    logic         wrap_q;
    logic         wrap_d;

    // Step target and wrap condition for the configured step direction.
    logic [N-1:0] idx_step_s;
    logic         step_wraps_s;

    // Compute where a single step would move the index and whether it wraps.
    always_comb begin
        idx_step_s   = idx_q + IDX_ONE;
        step_wraps_s = (idx_q == IDX_MAX);
`ifdef SCAN_DECODER_DOWN_EN
        if (dir) begin
            idx_step_s   = idx_q - IDX_ONE;
            step_wraps_s = (idx_q == IDX_ZERO);
        end else begin
            idx_step_s   = idx_q + IDX_ONE;
            step_wraps_s = (idx_q == IDX_MAX);
        end
`endif
    end

    // Next-state decode: enable gating, direct decode, or scan with
    // load > step > hold priority. In scan mode w tracks the next index so
    // w and idx are always consistent.
    always_comb begin
        w_d    = W_ZERO;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (!en) begin
            w_d    = W_ZERO;
            idx_d  = idx_q;
            wrap_d = 1'b0;
        end else if (!mode) begin
            w_d    = onehot(sel);
            idx_d  = idx_q;
            wrap_d = 1'b0;
        end else begin
            case ({load, step})
                2'b10, 2'b11: begin
                    idx_d  = sel;
                    wrap_d = 1'b0;
                end
                2'b01: begin
                    idx_d  = idx_step_s;
                    wrap_d = step_wraps_s;
                end
                default: begin
                    idx_d  = idx_q;
                    wrap_d = 1'b0;
                end
            endcase
            w_d = onehot(idx_d);
        end
    end

    // State registers; asynchronous reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q    <= W_ZERO;
            idx_q  <= IDX_ZERO;
            wrap_q <= 1'b0;
        end else begin
            w_q    <= w_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign w    = w_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//   Directed vectors for scan_decoder (N = 3). The driver applies one vector
//   per cycle and queues the hand-computed expected outputs; a monitor
//   process pops and compares one cycle later. Reset behaviour is checked
//   directly. With SCAN_DECODER_DOWN_EN defined, a decrement-wrap vector set
//   is added.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       load;
    logic       step;
`ifdef SCAN_DECODER_DOWN_EN
    logic       dir;
`endif
    logic [7:0] w;
    logic [2:0] idx;
    logic       wrap;

    scan_decoder #(.N(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .step  (step),
`ifdef SCAN_DECODER_DOWN_EN
        .dir   (dir),
`endif
        .w     (w),
        .idx   (idx),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [7:0] w;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   vec_no;

    // Monitor: one cycle after each driven vector, compare DUT to expected.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (w !== e.w || idx !== e.idx || wrap !== e.wrap) begin
                    bad++;
                    $display("FAIL vec%0d: got w=%h idx=%0d wrap=%b, want w=%h idx=%0d wrap=%b",
                             e.tag, w, idx, wrap, e.w, e.idx, e.wrap);
                end
            end
        end
    endtask

    // Direct (non-queued) check of current outputs, used around reset.
    task automatic check_now(input string name, input logic [7:0] ew,
                             input logic [2:0] ei, input logic ewr);
        total++;
        if (w !== ew || idx !== ei || wrap !== ewr) begin
            bad++;
            $display("FAIL %s: got w=%h idx=%0d wrap=%b, want w=%h idx=%0d wrap=%b",
                     name, w, idx, wrap, ew, ei, ewr);
        end
    endtask

    // Drive one vector at the falling edge and queue its expected result.
    task automatic drv(input logic e, input logic m, input logic [2:0] s,
                       input logic l, input logic st,
                       input logic [7:0] ew, input logic [2:0] ei, input logic ewr);
        exp_t x;
        @(negedge clk);
        en   = e;
        mode = m;
        sel  = s;
        load = l;
        step = st;
        vec_no++;
        x.tag  = vec_no;
        x.w    = ew;
        x.idx  = ei;
        x.wrap = ewr;
        exp_q.push_back(x);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        vec_no = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        sel    = 3'd0;
        load   = 1'b0;
        step   = 1'b0;
`ifdef SCAN_DECODER_DOWN_EN
        dir    = 1'b0;
`endif
        fork
            monitor_loop();
        join_none

        // Reset state, then held through a clock edge with enable high.
        #2;
        check_now("reset", 8'h00, 3'd0, 1'b0);
        en = 1'b1; mode = 1'b0; sel = 3'd5;
        @(posedge clk); #1;
        check_now("reset_held", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //   en    mode  sel   load  step  exp_w  idx   wrap
        // Direct decode; load/step ignored in direct mode.
        drv(1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 8'h20, 3'd0, 1'b0);
        drv(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);
        drv(1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 8'h80, 3'd0, 1'b0);
        // Scan load to 3, then enable gating with step held high.
        drv(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h08, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++)
            drv(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0);
        // Wrap: load 6, then step 7, 0 (wrap), 1.
        drv(1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 8'h40, 3'd6, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0);
        // Priority: load + step at idx 7 -> load wins, no wrap.
        drv(1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 8'h80, 3'd7, 1'b0);
        drv(1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 8'h80, 3'd7, 1'b0);
        // Wrapping step, then disable clears w and wrap but keeps idx.
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1);
        drv(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        // Mode switch: idx retained through direct mode, scan resumes.
        drv(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'h04, 3'd2, 1'b0);
        drv(1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 8'h40, 3'd2, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0);
        // Full round-robin walk from 3: 4,5,6,7,0(wrap),1,2,3.
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0);
        // Load 4, hold, then async reset between edges.
        drv(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 8'h10, 3'd4, 1'b0);
        drv(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // First post-reset step moves 0 -> 1.
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0);
`ifdef SCAN_DECODER_DOWN_EN
        // Decrement: load 0, step down wraps to 7, then 6.
        drv(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0);
        @(negedge clk);
        exp_q.push_back('{tag: 900, w: 8'h01, idx: 3'd0, wrap: 1'b0});
        dir = 1'b1;
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h80, 3'd7, 1'b1);
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0);
        dir = 1'b0;
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
